// File: rtl/f2i_share_arb.sv
// Round-robin sharing of one combinational float-to-int converter between NUM_REQ requesters,
// behind a two-stage pipeline (S1 operand, S2 result) with sticky status and a saturating counter.

module f2i_32 (
    input  logic [31:0] f,
    output logic [31:0] d,
    output logic        p_lost,
    output logic        denorm,
    output logic        invalid
);
    logic        sign;
    logic [7:0]  expo;
    logic [22:0] man;
    logic [4:0]  shamt;
    logic [54:0] sh;
    logic [31:0] mag;

    assign sign = f[31];
    assign expo = f[30:23];
    assign man  = f[22:0];

    always_comb begin
        d       = '0;
        p_lost  = 1'b0;
        denorm  = 1'b0;
        invalid = 1'b0;
        shamt   = '0;
        sh      = '0;
        mag     = '0;
        if (expo == 8'hFF) begin
            invalid = 1'b1;
            d       = 32'h8000_0000;
        end else if (expo == 8'h00) begin
            if (man != '0) begin
                denorm = 1'b1;
                p_lost = 1'b1;
            end
        end else if (expo < 8'd127) begin
            p_lost = 1'b1;
        end else if (expo >= 8'd158) begin
            // only -2^31 itself is representable at this magnitude
            d       = 32'h8000_0000;
            invalid = !(sign && expo == 8'd158 && man == '0);
        end else begin
            // fixed point with 23 fraction bits: integer part above, dropped bits below
            shamt  = 5'(expo - 8'd127);
            sh     = {31'b0, 1'b1, man} << shamt;
            mag    = sh[54:23];
            p_lost = |sh[22:0];
            d      = sign ? -mag : mag;
        end
    end
endmodule

module f2i_share_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  rsp_p_lost,
    output logic                  rsp_denorm,
    output logic                  rsp_invalid,
    input  logic                  stat_clr,
    output logic                  stat_invalid,
    output logic                  stat_p_lost,
    output logic [CNT_W-1:0]      stat_cnt
);
    logic              s1_valid_q;
    logic [31:0]       s1_data_q;
    logic [ID_W-1:0]   s1_id_q;
    logic [ID_W-1:0]   rr_q;
    logic              rsp_valid_q, rsp_p_lost_q, rsp_denorm_q, rsp_invalid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [31:0]       rsp_data_q;
    logic              stat_invalid_q, stat_p_lost_q;
    logic [CNT_W-1:0]  stat_cnt_q;

    logic              s1_adv, s2_adv, accept, xfer;
    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W:0]     scan;
    logic [31:0]       cv_d;
    logic              cv_p_lost, cv_denorm, cv_invalid;

    assign s2_adv = !rsp_valid_q || rsp_ready;
    assign s1_adv = !s1_valid_q || s2_adv;
    assign xfer   = rsp_valid_q && rsp_ready;

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan        = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan = {1'b0, rr_q} + (ID_W+1)'(k);
            if (scan >= (ID_W+1)'(NUM_REQ)) scan = scan - (ID_W+1)'(NUM_REQ);
            if (!grant_found && req_valid[scan[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan[ID_W-1:0];
            end
        end
    end

    assign accept = !rst && grant_found && s1_adv;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_id] = 1'b1;
    end

    f2i_32 u_cvt (
        .f       (s1_data_q),
        .d       (cv_d),
        .p_lost  (cv_p_lost),
        .denorm  (cv_denorm),
        .invalid (cv_invalid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_data_q      <= '0;
            s1_id_q        <= '0;
            rr_q           <= ID_W'(NUM_REQ - 1);
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_data_q     <= '0;
            rsp_p_lost_q   <= 1'b0;
            rsp_denorm_q   <= 1'b0;
            rsp_invalid_q  <= 1'b0;
            stat_invalid_q <= 1'b0;
            stat_p_lost_q  <= 1'b0;
            stat_cnt_q     <= '0;
        end else begin
            if (accept) begin
                rr_q       <= grant_id;
                s1_valid_q <= 1'b1;
                s1_data_q  <= req_data[32*int'(grant_id) +: 32];
                s1_id_q    <= grant_id;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end
            if (s2_adv) begin
                rsp_valid_q   <= s1_valid_q;
                rsp_id_q      <= s1_id_q;
                rsp_data_q    <= cv_d;
                rsp_p_lost_q  <= cv_p_lost;
                rsp_denorm_q  <= cv_denorm;
                rsp_invalid_q <= cv_invalid;
            end
            // a transfer in the clearing cycle is counted after the clear
            if (stat_clr) begin
                stat_cnt_q     <= xfer ? CNT_W'(1) : '0;
                stat_invalid_q <= xfer && rsp_invalid_q;
                stat_p_lost_q  <= xfer && rsp_p_lost_q;
            end else if (xfer) begin
                if (stat_cnt_q != '1) stat_cnt_q <= stat_cnt_q + 1'b1;
                stat_invalid_q <= stat_invalid_q | rsp_invalid_q;
                stat_p_lost_q  <= stat_p_lost_q | rsp_p_lost_q;
            end
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_p_lost   = rsp_p_lost_q;
    assign rsp_denorm   = rsp_denorm_q;
    assign rsp_invalid  = rsp_invalid_q;
    assign stat_invalid = stat_invalid_q;
    assign stat_p_lost  = stat_p_lost_q;
    assign stat_cnt     = stat_cnt_q;
endmodule

// File: tb/tb_f2i_share_arb.sv
// Bench for f2i_share_arb: per-requester operand queues, an in-flight response queue and
// a real-arithmetic float-to-int reference; a second instance with a 4-bit counter checks saturation.

module tb_f2i_share_arb;
    localparam int NR = 4;

    logic           clk = 1'b0;
    logic           rst, rsp_ready, stat_clr;
    logic [NR-1:0]  req_valid, req_ready, req_ready4;
    logic [127:0]   req_data;
    logic           rsp_valid, rsp_p_lost, rsp_denorm, rsp_invalid, stat_invalid, stat_p_lost;
    logic [1:0]     rsp_id;
    logic [31:0]    rsp_data;
    logic [15:0]    stat_cnt;
    logic           rsp_valid4, rsp_p_lost4, rsp_denorm4, rsp_invalid4, stat_invalid4, stat_p_lost4;
    logic [1:0]     rsp_id4;
    logic [31:0]    rsp_data4;
    logic [3:0]     stat_cnt4;

    always #5 clk = ~clk;

    f2i_share_arb #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_p_lost(rsp_p_lost), .rsp_denorm(rsp_denorm), .rsp_invalid(rsp_invalid),
        .stat_clr(stat_clr), .stat_invalid(stat_invalid), .stat_p_lost(stat_p_lost), .stat_cnt(stat_cnt)
    );

    f2i_share_arb #(.NUM_REQ(4), .ID_W(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_id(rsp_id4), .rsp_data(rsp_data4),
        .rsp_p_lost(rsp_p_lost4), .rsp_denorm(rsp_denorm4), .rsp_invalid(rsp_invalid4),
        .stat_clr(stat_clr), .stat_invalid(stat_invalid4), .stat_p_lost(stat_p_lost4), .stat_cnt(stat_cnt4)
    );

    typedef struct {
        logic [31:0] d;
        logic        pl, dn, inv;
        logic [1:0]  id;
        int          acc;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] src[NR][$];
    int          last, cyc, vectors, miscompares;
    int          mcnt, mcnt4;
    logic        msinv, mspl;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [1:0]  prev_id;
    logic [31:0] rrv[4] = '{32'hC000_0000, 32'h4120_0000, 32'h0000_0000, 32'h4F32_D05E};
    logic [31:0] spv[4] = '{32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0001, 32'hCF00_0000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // value = mantissa * 2^p, truncated toward zero; out of int32 range is invalid
    function automatic logic [34:0] ref_f2i(input logic [31:0] x);
        int          e = int'(x[30:23]);
        int          p;
        real         v;
        int          t;
        logic        pl = 1'b0, inv = 1'b0, dn;
        logic [31:0] d = '0;
        dn = (e == 0) && (x[22:0] != 0);
        if (e == 255) begin
            inv = 1'b1;
            d   = 32'h8000_0000;
        end else begin
            v = (e == 0) ? real'(x[22:0]) : real'(x[22:0]) + 8388608.0;
            p = (e == 0) ? -149 : e - 150;
            for (int k = 0; k < p; k++) v = v * 2.0;
            for (int k = 0; k < -p; k++) v = v / 2.0;
            if (x[31]) v = -v;
            if (v >= 2147483648.0 || v < -2147483648.0) begin
                inv = 1'b1;
                d   = 32'h8000_0000;
            end else begin
                t  = $rtoi(v);
                d  = t;
                pl = (real'(t) != v);
            end
        end
        return {inv, dn, pl, d};
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = (src[i].size() != 0);
            req_data[32*i +: 32] = req_valid[i] ? src[i][0] : 32'h0;
        end
    endtask

    task automatic cycle();
        logic [3:0]  er;
        logic [34:0] r;
        logic        adv, ev;
        int          g, idx;
        rsp_t        e;
        @(negedge clk);
        chk("stat_cnt", 32'(stat_cnt), 32'(mcnt));
        chk("stat_invalid", 32'(stat_invalid), 32'(msinv));
        chk("stat_p_lost", 32'(stat_p_lost), 32'(mspl));
        chk("stat_cnt4", 32'(stat_cnt4), 32'(mcnt4));
        adv = (q.size() < 2) || rsp_ready;
        g = -1;
        for (int k = 1; k <= NR; k++) begin
            idx = (last + k) % NR;
            if (g < 0 && src[idx].size() != 0) g = idx;
        end
        er = '0;
        if (g >= 0 && adv) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        ev = (q.size() != 0) && (cyc >= q[0].acc + 2);
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (prev_stall) begin
            chk("hold_data", rsp_data, prev_data);
            chk("hold_id", 32'(rsp_id), 32'(prev_id));
        end
        if (ev) begin
            e = q[0];
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_data", rsp_data, e.d);
            chk("rsp_flags", {29'b0, rsp_p_lost, rsp_denorm, rsp_invalid}, {29'b0, e.pl, e.dn, e.inv});
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_data  = rsp_data;
        prev_id    = rsp_id;
        if (ev && rsp_ready) begin
            void'(q.pop_front());
            if (stat_clr) begin
                mcnt = 1; mcnt4 = 1; msinv = e.inv; mspl = e.pl;
            end else begin
                if (mcnt < 65535) mcnt++;
                if (mcnt4 < 15) mcnt4++;
                msinv |= e.inv;
                mspl  |= e.pl;
            end
        end else if (stat_clr) begin
            mcnt = 0; mcnt4 = 0; msinv = 1'b0; mspl = 1'b0;
        end
        if (er != 0) begin
            r = ref_f2i(src[g][0]);
            q.push_back('{d: r[31:0], pl: r[32], dn: r[33], inv: r[34], id: 2'(g), acc: cyc});
            void'(src[g].pop_front());
            last = g;
        end
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    function automatic int pending();
        int s = q.size();
        for (int i = 0; i < NR; i++) s += src[i].size();
        return s;
    endfunction

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 200 && pending() != 0; i++) cycle();
        chk("drained", 32'(pending()), 32'h0);
        run(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive();
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        for (int i = 0; i < NR; i++) src[i].delete();
        last = NR - 1;
        mcnt = 0; mcnt4 = 0; msinv = 1'b0; mspl = 1'b0;
        prev_stall = 1'b0;
        drive();
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] x = $urandom;
        case ($urandom % 8)
            0, 1, 2, 3: x[30:23] = 8'(120 + $urandom % 45);
            4:          x[30:23] = ($urandom % 2 != 0) ? 8'hFF : 8'h00;
            default:    ;
        endcase
        return x;
    endfunction

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        rsp_ready = 1'b1; stat_clr = 1'b0; req_valid = '0; req_data = '0;
        do_reset();

        // single op: 1.5 -> 1 with p_lost
        src[0].push_back(32'h3FC0_0000);
        drive();
        run(4);

        // round robin, every requester busy
        for (int rep = 0; rep < 2; rep++)
            for (int i = 0; i < NR; i++) src[i].push_back(rrv[i]);
        drive();
        drain();

        // backpressure: two accepts then stall, then drain in order
        rsp_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            src[i].push_back(rnd_op());
            src[i].push_back(rnd_op());
        end
        drive();
        run(6);
        drain();

        // special values
        for (int i = 0; i < NR; i++) src[i].push_back(spv[i]);
        drive();
        drain();

        // status: three results, one invalid
        stat_clr = 1'b1; cycle(); stat_clr = 1'b0;
        src[1].push_back(32'h4120_0000);
        src[2].push_back(32'h7F80_0000);
        src[3].push_back(32'h4000_0000);
        drive();
        drain();
        chk("stat_cnt_3", 32'(stat_cnt), 32'd3);
        chk("stat_invalid_1", 32'(stat_invalid), 32'd1);

        // clear in the same cycle as a p_lost transfer
        src[0].push_back(32'h3FC0_0000);
        drive();
        run(2);
        stat_clr = 1'b1; cycle(); stat_clr = 1'b0;
        cycle();
        chk("clr_cnt", 32'(stat_cnt), 32'd1);
        chk("clr_p_lost", 32'(stat_p_lost), 32'd1);
        chk("clr_invalid", 32'(stat_invalid), 32'd0);

        // 20 transfers saturate a 4-bit counter
        stat_clr = 1'b1; cycle(); stat_clr = 1'b0;
        for (int n = 0; n < 20; n++) src[n % NR].push_back(rnd_op());
        drive();
        drain();
        chk("cnt4_sat", 32'(stat_cnt4), 32'd15);
        chk("cnt16_20", 32'(stat_cnt), 32'd20);

        // random traffic with random backpressure and clears
        for (int n = 0; n < 400; n++) begin
            if ($urandom % 2 != 0) begin
                int i = int'($urandom % NR);
                if (src[i].size() < 3) src[i].push_back(rnd_op());
            end
            rsp_ready = ($urandom % 4 != 0);
            stat_clr  = ($urandom % 32 == 0);
            drive();
            cycle();
        end
        stat_clr = 1'b0;
        drain();

        // reset with both stages full
        rsp_ready = 1'b0;
        for (int i = 0; i < NR; i++) src[i].push_back(rnd_op());
        drive();
        run(3);
        do_reset();
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_stat_cnt", 32'(stat_cnt), 32'd0);
        rsp_ready = 1'b1;
        for (int i = NR - 1; i >= 0; i--) src[i].push_back(rnd_op());
        drive();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
